fetch_decode: RTL and testbench

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/fetch_decode_if.sv | 45 ++++
 rtl/fetch_decode.sv | 141 ++++++++++++++
 tb/tb_fetch_decode.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_if.sv
// Bus between the fetch/decode stage and its surroundings: instruction memory
// port, stall input and the decoded register-file/ALU controls.
interface fetch_decode_if;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [4:0]  read_reg_num1;
  logic [4:0]  read_reg_num2;
  logic [4:0]  write_reg;
  logic [3:0]  alu_control;
  logic        regwrite;
  logic        illegal;
  logic [31:0] pc;
  logic [31:0] instret;

  // Stage side: drives the memory address and the decode results.
  modport master (
    input  stall,
    input  imem_rdata,
    output imem_addr,
    output read_reg_num1,
    output read_reg_num2,
    output write_reg,
    output alu_control,
    output regwrite,
    output illegal,
    output pc,
    output instret
  );

  // Environment side: memory, stall source and consumers of the decode.
  modport slave (
    output stall,
    output imem_rdata,
    input  imem_addr,
    input  read_reg_num1,
    input  read_reg_num2,
    input  write_reg,
    input  alu_control,
    input  regwrite,
    input  illegal,
    input  pc,
    input  instret
  );
endinterface

// File: rtl/fetch_decode.sv
// Two-cycle fetch/decode stage for RV32I R-type instructions. FETCH presents
// pc to a synchronous-read memory, DECODE consumes the returned word. Any
// unsupported word parks the stage in HALT until reset.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clock,
  input logic          reset,
  fetch_decode_if.master bus
);

  typedef enum logic [1:0] {FETCH, DECODE, HALT} state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // Only the register-number fields of the instruction are needed after decode.
  logic [4:0]  ir_rs1_q, ir_rs1_d;
  logic [4:0]  ir_rs2_q, ir_rs2_d;
  logic [4:0]  ir_rd_q, ir_rd_d;
  logic [3:0]  alu_q, alu_d;
  logic        regwrite_q, regwrite_d;
  logic        illegal_q, illegal_d;
  logic [31:0] instret_q, instret_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        dec_legal;
  logic [3:0]  dec_alu;

  assign opcode = bus.imem_rdata[6:0];
  assign funct3 = bus.imem_rdata[14:12];
  assign funct7 = bus.imem_rdata[31:25];

  // Instruction decode of the word currently returned by memory.
  always_comb begin
    dec_legal = 1'b0;
    dec_alu   = 4'b0010;
    if (opcode == OP_RTYPE) begin
      if (funct7 == F7_BASE) begin
        dec_legal = 1'b1;
        case (funct3)
          3'b000:  dec_alu = 4'b0010; // ADD
          3'b001:  dec_alu = 4'b0100; // SLL
          3'b010:  dec_alu = 4'b0111; // SLT
          3'b011:  dec_alu = 4'b1001; // SLTU
          3'b100:  dec_alu = 4'b0011; // XOR
          3'b101:  dec_alu = 4'b0101; // SRL
          3'b110:  dec_alu = 4'b0001; // OR
          default: dec_alu = 4'b0000; // AND
        endcase
      end else if (funct7 == F7_ALT) begin
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_alu = 4'b0110; end // SUB
          3'b101: begin dec_legal = 1'b1; dec_alu = 4'b1000; end // SRA
          default: dec_legal = 1'b0;
        endcase
      end
    end
  end

  // Next-state logic: stall freezes everything; HALT is absorbing.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_rs1_d   = ir_rs1_q;
    ir_rs2_d   = ir_rs2_q;
    ir_rd_d    = ir_rd_q;
    alu_d      = alu_q;
    regwrite_d = 1'b0;
    illegal_d  = illegal_q;
    instret_d  = instret_q;
    case (state_q)
      FETCH: begin
        if (!bus.stall) state_d = DECODE;
      end
      DECODE: begin
        if (!bus.stall) begin
          if (dec_legal) begin
            state_d    = FETCH;
            ir_rs1_d   = bus.imem_rdata[19:15];
            ir_rs2_d   = bus.imem_rdata[24:20];
            ir_rd_d    = bus.imem_rdata[11:7];
            alu_d      = dec_alu;
            regwrite_d = (bus.imem_rdata[11:7] != 5'd0);
            pc_d       = pc_q + 32'd4;
            instret_d  = instret_q + 32'd1;
          end else begin
            state_d   = HALT;
            illegal_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // State register with synchronous reset taking priority over stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      ir_rs1_q   <= 5'd0;
      ir_rs2_q   <= 5'd0;
      ir_rd_q    <= 5'd0;
      alu_q      <= 4'b0010;
      regwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
      instret_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_rs1_q   <= ir_rs1_d;
      ir_rs2_q   <= ir_rs2_d;
      ir_rd_q    <= ir_rd_d;
      alu_q      <= alu_d;
      regwrite_q <= regwrite_d;
      illegal_q  <= illegal_d;
      instret_q  <= instret_d;
    end
  end

  // A stall in the pulse cycle kills the write; the pulse is never replayed
  // because regwrite_q always clears on the following edge.
  assign bus.regwrite      = regwrite_q & ~bus.stall;
  assign bus.imem_addr     = pc_q;
  assign bus.pc            = pc_q;
  assign bus.read_reg_num1 = ir_rs1_q;
  assign bus.read_reg_num2 = ir_rs2_q;
  assign bus.write_reg     = ir_rd_q;
  assign bus.alu_control   = alu_q;
  assign bus.illegal       = illegal_q;
  assign bus.instret       = instret_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: main instance at RESET_PC 0 plus a second
// instance at 0xFFFF_FFFC for the pc wrap case. Both read one shared memory.
module tb_fetch_decode;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] mem [0:63];

  fetch_decode_if bus ();
  fetch_decode_if bus2 ();

  fetch_decode u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clock = ~clock;

  // Synchronous-read instruction memories.
  always @(posedge clock) begin
    bus.imem_rdata  <= mem[bus.imem_addr[7:2]];
    bus2.imem_rdata <= mem[bus2.imem_addr[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
    mem[0]  = 32'h002081B3; // add  x3,x1,x2
    mem[1]  = 32'h40308233; // sub  x4,x1,x3
    mem[2]  = 32'h0020D2B3; // srl  x5,x1,x2
    mem[3]  = 32'h00208033; // add  x0,x1,x2
    mem[4]  = 32'h0020F333; // and  x6,x1,x2
    mem[5]  = 32'h0020E3B3; // or   x7,x1,x2
    mem[6]  = 32'h4020D433; // sra  x8,x1,x2
    mem[63] = 32'h002081B3; // add at 0xFFFF_FFFC for the wrap instance
    bus.stall  = 1'b0;
    bus2.stall = 1'b0;

    // Reset state
    reset = 1'b1;
    tick(2);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_instret", bus.instret, 32'h0);
    check("rst_alu", 32'(bus.alu_control), 32'h2);
    check("rst_regwrite", 32'(bus.regwrite), 32'h0);
    check("rst_illegal", 32'(bus.illegal), 32'h0);
    check("rst_rs1", 32'(bus.read_reg_num1), 32'h0);
    check("rst_wrap_pc", bus2.pc, 32'hFFFF_FFFC);
    reset = 1'b0;

    // add x3,x1,x2 retires two cycles after reset
    tick(1);
    check("fetch_pc_hold", bus.pc, 32'h0);
    tick(1);
    check("add_rs1", 32'(bus.read_reg_num1), 32'd1);
    check("add_rs2", 32'(bus.read_reg_num2), 32'd2);
    check("add_rd", 32'(bus.write_reg), 32'd3);
    check("add_alu", 32'(bus.alu_control), 32'h2);
    check("add_regwrite", 32'(bus.regwrite), 32'h1);
    check("add_pc", bus.pc, 32'h4);
    check("add_instret", bus.instret, 32'h1);
    check("add_addr", bus.imem_addr, 32'h4);
    check("wrap_pc", bus2.pc, 32'h0);
    check("wrap_instret", bus2.instret, 32'h1);
    check("wrap_regwrite", 32'(bus2.regwrite), 32'h1);

    // sub then srl, pulses two cycles apart
    tick(1);
    check("gap_regwrite", 32'(bus.regwrite), 32'h0);
    tick(1);
    check("sub_alu", 32'(bus.alu_control), 32'h6);
    check("sub_rd", 32'(bus.write_reg), 32'd4);
    check("sub_regwrite", 32'(bus.regwrite), 32'h1);
    tick(1);
    check("gap2_regwrite", 32'(bus.regwrite), 32'h0);
    tick(1);
    check("srl_alu", 32'(bus.alu_control), 32'h5);
    check("srl_regwrite", 32'(bus.regwrite), 32'h1);
    check("srl_instret", bus.instret, 32'h3);
    check("srl_pc", bus.pc, 32'hC);

    // add x0: no write, but pc and instret advance
    tick(2);
    check("x0_regwrite", 32'(bus.regwrite), 32'h0);
    check("x0_pc", bus.pc, 32'h10);
    check("x0_instret", bus.instret, 32'h4);

    // Stall held three cycles in DECODE
    tick(1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("stall_addr", bus.imem_addr, 32'h10);
      check("stall_instret", bus.instret, 32'h4);
      check("stall_regwrite", 32'(bus.regwrite), 32'h0);
    end
    bus.stall = 1'b0;
    tick(1);
    check("and_alu", 32'(bus.alu_control), 32'h0);
    check("and_rd", 32'(bus.write_reg), 32'd6);
    check("and_regwrite", 32'(bus.regwrite), 32'h1);
    check("and_pc", bus.pc, 32'h14);
    tick(1);
    check("and_single_pulse", 32'(bus.regwrite), 32'h0);

    // Stall in the pulse cycle suppresses the write with no replay
    tick(1);
    check("or_alu", 32'(bus.alu_control), 32'h1);
    check("or_regwrite", 32'(bus.regwrite), 32'h1);
    bus.stall = 1'b1;
    #1;
    check("or_suppressed", 32'(bus.regwrite), 32'h0);
    tick(1);
    bus.stall = 1'b0;
    #1;
    check("or_no_replay", 32'(bus.regwrite), 32'h0);
    check("or_pc", bus.pc, 32'h18);
    check("or_instret", bus.instret, 32'h6);

    // sra
    tick(2);
    check("sra_alu", 32'(bus.alu_control), 32'h8);
    check("sra_pc", bus.pc, 32'h1C);

    // Second program: add x0, sltu, then illegal addi at address 8
    mem[0] = 32'h00208033;
    mem[1] = 32'h0020B4B3; // sltu x9,x1,x2
    mem[2] = 32'h00000013; // addi x0,x0,0
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    check("sltu_alu", 32'(bus.alu_control), 32'h9);
    check("sltu_rd", 32'(bus.write_reg), 32'd9);
    check("sltu_instret", bus.instret, 32'h2);
    tick(2);
    check("ill_flag", 32'(bus.illegal), 32'h1);
    check("ill_pc", bus.pc, 32'h8);
    check("ill_alu_kept", 32'(bus.alu_control), 32'h9);
    check("ill_rd_kept", 32'(bus.write_reg), 32'd9);
    check("ill_regwrite", 32'(bus.regwrite), 32'h0);
    check("ill_instret", bus.instret, 32'h2);
    for (int i = 0; i < 10; i++) begin
      bus.stall = i[0];
      tick(1);
      check("halt_regwrite", 32'(bus.regwrite), 32'h0);
    end
    bus.stall = 1'b0;
    check("halt_pc", bus.pc, 32'h8);
    check("halt_illegal", 32'(bus.illegal), 32'h1);
    check("halt_instret", bus.instret, 32'h2);

    // Reset clears HALT, even with stall asserted
    bus.stall = 1'b1;
    reset = 1'b1;
    tick(1);
    check("clr_illegal", 32'(bus.illegal), 32'h0);
    check("clr_pc", bus.pc, 32'h0);
    bus.stall = 1'b0;
    reset = 1'b0;

    // Reset mid-DECODE discards the fetched word
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_pc", bus.pc, 32'h0);
    check("mid_instret", bus.instret, 32'h0);
    tick(1);
    check("mid_refetch_pc", bus.pc, 32'h0);
    tick(1);
    check("mid_redecode_pc", bus.pc, 32'h4);
    check("mid_redecode_instret", bus.instret, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
